// File: rtl/decoder_arrhythmia_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg -- shared definitions for the arrhythmia VAE decoder.
//
// Contents:
//   BITSIZE / FRAC_BITS     sign-magnitude Q5.10 word geometry
//   N_HID / N_OUT           layer sizes (1 -> 6 -> 10)
//   ACC_W / SM_MAX          accumulator width and largest SM magnitude
//   state_t                 decoder FSM states
//   sm_to_tc / tc_to_sm     sign-magnitude <-> two's-complement conversion,
//                           the latter saturating and never producing -0
//   softplus_pwl / sigmoid_hard
//                           piecewise-linear activations, only referenced
//                           when the top is built with DEC_ACT_EN
// -----------------------------------------------------------------------------
package dec_pkg;

    localparam int BITSIZE   = 16;
    localparam int FRAC_BITS = 10;
    localparam int N_HID     = 6;
    localparam int N_OUT     = 10;
    localparam int ACC_W     = 24;
    localparam logic [BITSIZE-1:0] SM_MAX = 16'h7FFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_L1   = 3'd1,
        S_ACT1 = 3'd2,
        S_L2   = 3'd3,
        S_ACT2 = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Activation breakpoints in two's-complement Q5.10
    localparam logic signed [ACC_W-1:0] ONE_TC  = 24'sd1024;
    localparam logic signed [ACC_W-1:0] HALF_TC = 24'sd512;
    localparam logic signed [ACC_W-1:0] TWO_TC  = 24'sd2048;

    function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic [BITSIZE-1:0] v);
        logic signed [ACC_W-1:0] m;
        m = {{(ACC_W-BITSIZE+1){1'b0}}, v[BITSIZE-2:0]};
        return v[BITSIZE-1] ? -m : m;
    endfunction

    function automatic logic [BITSIZE-1:0] tc_to_sm(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-1:0] mag;
        logic [ACC_W-1:0] lim;
        mag = a[ACC_W-1] ? $unsigned(-a) : $unsigned(a);
        lim = {{(ACC_W-BITSIZE){1'b0}}, SM_MAX};
        if (mag == '0) begin
            return '0;
        end
        if (mag > lim) begin
            return {a[ACC_W-1], SM_MAX[BITSIZE-2:0]};
        end
        return {a[ACC_W-1], mag[BITSIZE-2:0]};
    endfunction

    // softplus ~ 0 below -2, identity above +2, straight line (x+2)/2 between
    function automatic logic [BITSIZE-1:0] softplus_pwl(input logic [BITSIZE-1:0] x);
        logic signed [ACC_W-1:0] t;
        t = sm_to_tc(x);
        if (t <= -TWO_TC) begin
            return '0;
        end
        if (t >= TWO_TC) begin
            return x;
        end
        return tc_to_sm((t + TWO_TC) >>> 1);
    endfunction

    // hard sigmoid: clamp(x/4 + 0.5, 0, 1)
    function automatic logic [BITSIZE-1:0] sigmoid_hard(input logic [BITSIZE-1:0] x);
        logic signed [ACC_W-1:0] r;
        r = (sm_to_tc(x) >>> 2) + HALF_TC;
        if (r < 0) begin
            return '0;
        end
        if (r > ONE_TC) begin
            return tc_to_sm(ONE_TC);
        end
        return tc_to_sm(r);
    endfunction

endpackage

// File: rtl/decoder_arrhythmia_mac.sv
// -----------------------------------------------------------------------------
// dec_mac_sm -- single sign-magnitude multiplier feeding a 24-bit
// two's-complement accumulator, shared by both decoder layers.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_a, i_b        SM Q5.10 operands
//   i_bias          SM Q5.10 bias used as the sum base when i_load is high
//   i_load          clear/load-bias: sum = bias + a*b, accumulator takes it
//   i_acc           accumulate: sum = acc + a*b, accumulator takes it
//   o_sum_sm        current sum (base + product) saturated back to SM; the
//                   caller captures it on the cycle that finishes a neuron,
//                   so the last term never needs an extra cycle
// -----------------------------------------------------------------------------
module dec_mac_sm
    import dec_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [BITSIZE-1:0] i_a,
    input  logic [BITSIZE-1:0] i_b,
    input  logic [BITSIZE-1:0] i_bias,
    input  logic               i_load,
    input  logic               i_acc,
    output logic [BITSIZE-1:0] o_sum_sm
);

    localparam int PF_W = 2 * (BITSIZE - 1);   // full magnitude product width
    localparam int PM_W = PF_W - FRAC_BITS;    // product magnitude after >>10

    logic signed [ACC_W-1:0] r_acc;
    logic [PF_W-1:0]         w_prod_full;
    logic [PM_W-1:0]         w_prod_mag;
    logic signed [ACC_W-1:0] w_prod_pos;
    logic signed [ACC_W-1:0] w_prod_tc;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_sum;

    // Magnitude product truncated back to Q5.10; a zero magnitude with a
    // negative sign still becomes a plain zero in two's complement.
    assign w_prod_full = i_a[BITSIZE-2:0] * i_b[BITSIZE-2:0];
    assign w_prod_mag  = w_prod_full[PF_W-1:FRAC_BITS];
    assign w_prod_pos  = {{(ACC_W-PM_W){1'b0}}, w_prod_mag};
    assign w_prod_tc   = (i_a[BITSIZE-1] ^ i_b[BITSIZE-1]) ? -w_prod_pos : w_prod_pos;

    assign w_base   = i_load ? sm_to_tc(i_bias) : r_acc;
    assign w_sum    = w_base + w_prod_tc;
    assign o_sum_sm = tc_to_sm(w_sum);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_load || i_acc) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/decoder_arrhythmia.sv
// -----------------------------------------------------------------------------
// decoder_arrhythmia -- latent-to-signal decoder of the arrhythmia VAE.
// One latent z (SM Q5.10) goes through a 1->6 hidden layer and a 6->10
// output layer, both computed on one time-multiplexed MAC (dec_mac_sm).
//
// Build option: define DEC_ACT_EN to apply softplus to the hidden layer and
// sigmoid to the output layer, each taking ACT_LAT wait cycles. Without it
// both layers are linear and the activation states take zero cycles.
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   z, z_valid, z_ready   latent input handshake (z_ready = idle)
//   w_dec_1, b_dec_1   hidden weights/biases, element n at [16n +: 16]
//   w_dec_2            output weights, element j*6+k: hidden k -> output j
//   b_dec_2            output biases
//   y, y_valid, y_ready   10-element result handshake, y held until taken
//   busy               high whenever the FSM is not idle
// Weights and biases are read live and must be stable for the whole run.
// -----------------------------------------------------------------------------
module decoder_arrhythmia #(
    parameter int BITSIZE = 16,
    parameter int ACT_LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BITSIZE-1:0]    z,
    input  logic                  z_valid,
    output logic                  z_ready,
    input  logic [BITSIZE*6-1:0]  w_dec_1,
    input  logic [BITSIZE*6-1:0]  b_dec_1,
    input  logic [BITSIZE*60-1:0] w_dec_2,
    input  logic [BITSIZE*10-1:0] b_dec_2,
    output logic [BITSIZE*10-1:0] y,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic                  busy
);

    import dec_pkg::*;

`ifdef DEC_ACT_EN
    localparam bit ACT_EN = 1'b1;
`else
    localparam bit ACT_EN = 1'b0;
`endif
    localparam int         ACT_CYC   = ACT_EN ? ACT_LAT : 0;
    localparam logic [7:0] WAIT_LAST = 8'(ACT_CYC - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [2:0]               r_n;
    logic [3:0]               r_j;
    logic [2:0]               r_k;
    logic [7:0]               r_wait;
    logic [BITSIZE-1:0]       r_z;
    logic [BITSIZE-1:0]       r_h     [N_HID];
    logic [BITSIZE-1:0]       r_y_pre [N_OUT];
    logic [BITSIZE*N_OUT-1:0] r_y;
    logic [BITSIZE*N_OUT-1:0] w_y_final;

    logic [5:0]               w_widx;
    logic [BITSIZE-1:0]       w_mac_a;
    logic [BITSIZE-1:0]       w_mac_b;
    logic [BITSIZE-1:0]       w_mac_bias;
    logic                     w_mac_load;
    logic                     w_mac_acc;
    logic [BITSIZE-1:0]       w_mac_sm;

    assign w_widx = 6'(r_j) * 6'(N_HID) + 6'(r_k);

    // Outputs decode from state only, so nothing combinational reaches
    // them from z_valid or y_ready.
    assign z_ready = (r_state == S_IDLE);
    assign y_valid = (r_state == S_DONE);
    assign busy    = (r_state != S_IDLE);
    assign y       = r_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_mac_a    = r_z;
        w_mac_b    = '0;
        w_mac_bias = '0;
        w_mac_load = 1'b0;
        w_mac_acc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (z_valid) begin
                    w_next = S_L1;
                end
            end
            S_L1: begin
                // Hidden neuron n is bias + one product: done in one cycle
                w_mac_b    = w_dec_1[BITSIZE*r_n +: BITSIZE];
                w_mac_bias = b_dec_1[BITSIZE*r_n +: BITSIZE];
                w_mac_load = 1'b1;
                if (r_n == 3'(N_HID-1)) begin
                    w_next = (ACT_CYC == 0) ? S_L2 : S_ACT1;
                end
            end
            S_ACT1: begin
                if (r_wait == WAIT_LAST) begin
                    w_next = S_L2;
                end
            end
            S_L2: begin
                w_mac_a    = r_h[r_k];
                w_mac_b    = w_dec_2[BITSIZE*w_widx +: BITSIZE];
                w_mac_bias = b_dec_2[BITSIZE*r_j +: BITSIZE];
                w_mac_load = (r_k == 3'd0);
                w_mac_acc  = (r_k != 3'd0);
                if (r_j == 4'(N_OUT-1) && r_k == 3'(N_HID-1)) begin
                    w_next = (ACT_CYC == 0) ? S_DONE : S_ACT2;
                end
            end
            S_ACT2: begin
                if (r_wait == WAIT_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (y_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    dec_mac_sm u_mac (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_a      (w_mac_a),
        .i_b      (w_mac_b),
        .i_bias   (w_mac_bias),
        .i_load   (w_mac_load),
        .i_acc    (w_mac_acc),
        .o_sum_sm (w_mac_sm)
    );

`ifdef DEC_ACT_EN
    logic [BITSIZE-1:0] w_h_act [N_HID];
    logic [BITSIZE-1:0] w_y_act [N_OUT];

    for (genvar gi = 0; gi < N_HID; gi++) begin : g_softplus
        assign w_h_act[gi] = softplus_pwl(r_h[gi]);
    end

    for (genvar gj = 0; gj < N_OUT; gj++) begin : g_sigmoid
        assign w_y_act[gj] = sigmoid_hard(r_y_pre[gj]);
    end

    // y is loaded at the end of ACT2, when every y_pre is already stored
    always_comb begin
        w_y_final = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_y_final[BITSIZE*j +: BITSIZE] = w_y_act[j];
        end
    end
`else
    // y is loaded on the final L2 cycle, so the last neuron comes straight
    // from the MAC rather than from y_pre, which is written on that same edge
    always_comb begin
        w_y_final = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_y_final[BITSIZE*j +: BITSIZE] = r_y_pre[j];
        end
        if (r_state == S_L2) begin
            w_y_final[BITSIZE*(N_OUT-1) +: BITSIZE] = w_mac_sm;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_z    <= '0;
            r_n    <= '0;
            r_j    <= '0;
            r_k    <= '0;
            r_wait <= '0;
            r_y    <= '0;
            for (int i = 0; i < N_HID; i++) begin
                r_h[i] <= '0;
            end
            for (int i = 0; i < N_OUT; i++) begin
                r_y_pre[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (z_valid) begin
                        r_z <= z;
                        r_n <= '0;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                S_L1: begin
                    r_h[r_n] <= w_mac_sm;
                    r_n      <= r_n + 3'd1;
                end
                S_L2: begin
                    if (r_k == 3'(N_HID-1)) begin
                        r_y_pre[r_j] <= w_mac_sm;
                        r_k          <= '0;
                        r_j          <= r_j + 4'd1;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                default: ;
            endcase

            // Wait counter restarts on every entry into an activation state
            if ((r_state == S_ACT1 || r_state == S_ACT2) && w_next == r_state) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= '0;
            end

`ifdef DEC_ACT_EN
            if (r_state == S_ACT1 && w_next == S_L2) begin
                for (int i = 0; i < N_HID; i++) begin
                    r_h[i] <= w_h_act[i];
                end
            end
`endif

            if (w_next == S_DONE && r_state != S_DONE) begin
                r_y <= w_y_final;
            end
        end
    end

endmodule

// File: tb/tb_decoder_arrhythmia.sv
// -----------------------------------------------------------------------------
// tb_decoder_arrhythmia -- directed bench for decoder_arrhythmia (default,
// linear build). Expected values are hand-computed Q5.10 sign-magnitude words.
// -----------------------------------------------------------------------------
module tb_decoder_arrhythmia;

`ifdef DEC_ACT_EN
    localparam int LAT = 72;
`else
    localparam int LAT = 66;
`endif

    logic         clk;
    logic         reset;
    logic [15:0]  z;
    logic         z_valid;
    logic         z_ready;
    logic [95:0]  w_dec_1;
    logic [95:0]  b_dec_1;
    logic [959:0] w_dec_2;
    logic [159:0] b_dec_2;
    logic [159:0] y;
    logic         y_valid;
    logic         y_ready;
    logic         busy;

    int total;
    int bad;
    int lat;
    logic [159:0] exp_y;

    decoder_arrhythmia #(.BITSIZE(16), .ACT_LAT(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .z       (z),
        .z_valid (z_valid),
        .z_ready (z_ready),
        .w_dec_1 (w_dec_1),
        .b_dec_1 (b_dec_1),
        .w_dec_2 (w_dec_2),
        .b_dec_2 (b_dec_2),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [159:0] rep(input logic [15:0] v);
        return {10{v}};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_uniform(input logic [15:0] w1, input logic [15:0] b1,
                               input logic [15:0] w2, input logic [15:0] b2);
        for (int n = 0; n < 6; n++) begin
            w_dec_1[16*n +: 16] = w1;
            b_dec_1[16*n +: 16] = b1;
        end
        for (int m = 0; m < 60; m++) begin
            w_dec_2[16*m +: 16] = w2;
        end
        for (int j = 0; j < 10; j++) begin
            b_dec_2[16*j +: 16] = b2;
        end
    endtask

    // Returns at the falling edge right after the accept edge E0
    task automatic launch(input logic [15:0] zin);
        @(negedge clk);
        z       = zin;
        z_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        z_valid = 1'b0;
        z       = '0;
    endtask

    // lat = number of rising edges after E0 until y_valid is seen (bounded)
    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!y_valid && cnt < 200) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        y_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        y_ready = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        z       = '0;
        z_valid = 1'b0;
        y_ready = 1'b0;
        set_uniform(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_z_ready", 160'(z_ready), 160'(1'b1));
        chk("rst_y_valid", 160'(y_valid), 160'(1'b0));
        chk("rst_busy",    160'(busy),    160'(1'b0));
        chk("rst_y",       y,             160'(0));

        // Linear path: h = 1.0, y = 6 * 0.5 = 3.0
        set_uniform(16'h0400, 16'h0000, 16'h0200, 16'h0000);
        launch(16'h0400);
        chk("lin_busy_mid",    160'(busy),    160'(1'b1));
        chk("lin_zready_mid",  160'(z_ready), 160'(1'b0));
        wait_valid(lat);
        chk("lin_latency",     160'(lat),     160'(LAT));
        chk("lin_y",           y,             rep(16'h0C00));
        handshake();
        chk("lin_yvalid_after", 160'(y_valid), 160'(1'b0));
        chk("lin_zready_after", 160'(z_ready), 160'(1'b1));

        // Sign: h = -1.0, y = -3.0
        launch(16'h8400);
        wait_valid(lat);
        chk("sign_latency", 160'(lat), 160'(LAT));
        chk("sign_y",       y,         rep(16'h8C00));
        handshake();

        // Saturation: 31*31 overflows in h, 6 * 31.99 overflows in y
        set_uniform(16'h7C00, 16'h0000, 16'h0400, 16'h0000);
        launch(16'h7C00);
        wait_valid(lat);
        chk("sat_y", y, rep(16'h7FFF));
        handshake();

        // Negative zero: h = -1 + 1 = 0; negative weights give -0 products
        set_uniform(16'h0400, 16'h8400, 16'h8200, 16'h0000);
        launch(16'h0400);
        wait_valid(lat);
        chk("negzero_y", y, rep(16'h0000));
        handshake();

        // Mixed signs with biases: h = 2 + 1 = 3, y = 0.5 - 6*0.75 = -4.0
        set_uniform(16'h0400, 16'h0400, 16'h8100, 16'h0200);
        launch(16'h0800);
        wait_valid(lat);
        chk("mixed_y", y, rep(16'h9000));
        handshake();

        // Indexing: w1[n]=(n+1), b1[n]=n/4 -> h[n]=(n+1)+n/4;
        // only w2[j*6 + j%6]=1.0, b2[j]=j/4 -> y[j]=h[j%6]+j/4
        for (int n = 0; n < 6; n++) begin
            w_dec_1[16*n +: 16] = 16'((n + 1) * 1024);
            b_dec_1[16*n +: 16] = 16'(n * 256);
        end
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < 6; k++) begin
                w_dec_2[16*(j*6+k) +: 16] = (k == j % 6) ? 16'h0400 : 16'h0000;
            end
            b_dec_2[16*j +: 16] = 16'(j * 256);
        end
        launch(16'h0400);
        wait_valid(lat);
        chk("idx_latency", 160'(lat), 160'(LAT));
        for (int j = 0; j < 10; j++) begin
            exp_y[15:0] = 16'(((j % 6) + 1) * 1024 + (j % 6) * 256 + j * 256);
            chk($sformatf("idx_y%0d", j), 160'(y[16*j +: 16]), 160'(exp_y[15:0]));
        end
        handshake();

        // Backpressure: y_ready low 10 cycles, z_valid pulse must be ignored
        set_uniform(16'h0400, 16'h0000, 16'h0200, 16'h0000);
        launch(16'h0400);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            chk("bp_y",       y,             rep(16'h0C00));
            chk("bp_zready",  160'(z_ready), 160'(1'b0));
            chk("bp_yvalid",  160'(y_valid), 160'(1'b1));
            z_valid = (i == 3);
            z       = (i == 3) ? 16'h1234 : 16'h0000;
            @(negedge clk);
        end
        z_valid = 1'b0;
        handshake();
        chk("bp_zready_after", 160'(z_ready), 160'(1'b1));
        chk("bp_busy_after",   160'(busy),    160'(1'b0));
        @(negedge clk);
        chk("bp_still_idle",   160'(busy),    160'(1'b0));

        // Reset mid-operation at E0+30, then a clean run afterwards
        launch(16'h8400);
        repeat (30) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_y",      y,             160'(0));
        chk("rstmid_yvalid", 160'(y_valid), 160'(1'b0));
        chk("rstmid_busy",   160'(busy),    160'(1'b0));
        @(negedge clk);
        reset = 1'b1;
        launch(16'h0400);
        wait_valid(lat);
        chk("rstmid_latency", 160'(lat), 160'(LAT));
        chk("rstmid_y_after", y,         rep(16'h0C00));
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
